// File: rtl/rs_alu_sched_pkg.sv
// Shared types and widths for the ALU reservation station.
package rs_alu_sched_pkg;

    localparam int OP_W        = 6;
    localparam int OPTYPE_W    = 3;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int ROB_IDX_W   = 4;
    localparam int RS_SIZE_DEF = 16;
    localparam int RS_IDX_W_DEF = 4;

    // Operation encodings as produced by decode; the scheduler never decodes them.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_ADDI  = 6'd3,
        OP_LUI   = 6'd4,
        OP_AUIPC = 6'd5,
        OP_JAL   = 6'd6,
        OP_JALR  = 6'd7,
        OP_BEQ   = 6'd8
    } op_e;

    typedef enum logic [OPTYPE_W-1:0] {
        OPT_ARITH  = 3'd0,
        OPT_ARITHI = 3'd1,
        OPT_BRANCH = 3'd2,
        OPT_JUMP   = 3'd3,
        OPT_UPPER  = 3'd4
    } optype_e;

    // One reservation-station slot (busy is kept as a separate vector).
    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [OPTYPE_W-1:0]  optype;
        logic [DATA_W-1:0]    vj;
        logic [DATA_W-1:0]    vk;
        logic [ROB_IDX_W-1:0] qj;
        logic [ROB_IDX_W-1:0] qk;
        logic                 rj;
        logic                 rk;
        logic [DATA_W-1:0]    imm;
        logic [ADDR_W-1:0]    pc;
        logic [ROB_IDX_W-1:0] rob;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_sched_prio_enc.sv
// Lowest-index-set priority encoder with a found flag.
module rs_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu_sched.sv
// Reservation station and issue scheduler for the integer ALU.
module rs_alu_sched
    import rs_alu_sched_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = RS_IDX_W_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 dis_valid,
    input  logic [OP_W-1:0]      dis_op,
    input  logic [OPTYPE_W-1:0]  dis_opType,
    input  logic [DATA_W-1:0]    dis_rs1_val,
    input  logic [DATA_W-1:0]    dis_rs2_val,
    input  logic                 dis_rs1_rdy,
    input  logic                 dis_rs2_rdy,
    input  logic [ROB_IDX_W-1:0] dis_rs1_tag,
    input  logic [ROB_IDX_W-1:0] dis_rs2_tag,
    input  logic [DATA_W-1:0]    dis_imm,
    input  logic [ADDR_W-1:0]    dis_PC,
    input  logic [ROB_IDX_W-1:0] dis_rob_index,
    input  logic                 alu_ready,
    input  logic [ROB_IDX_W-1:0] alu_rob_index,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 lsb_ready,
    input  logic [ROB_IDX_W-1:0] lsb_rob_index,
    input  logic [DATA_W-1:0]    lsb_result,
    output logic                 rs_full,
    output logic                 rs_to_alu_ready,
    output logic [OP_W-1:0]      rs_to_alu_op,
    output logic [OPTYPE_W-1:0]  rs_to_alu_opType,
    output logic [DATA_W-1:0]    rs_to_alu_rs1,
    output logic [DATA_W-1:0]    rs_to_alu_rs2,
    output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index,
    output logic [ADDR_W-1:0]    rs_to_alu_PC,
    output logic [DATA_W-1:0]    rs_to_alu_imm
);

    rs_entry_t             r_ent [RS_SIZE];
    logic [RS_SIZE-1:0]    r_busy;
    rs_entry_t             r_iss;
    logic                  r_iss_vld;

    logic [RS_SIZE-1:0]    w_cand;
    logic [RS_IDX_W-1:0]   w_free_idx;
    logic                  w_free_found;
    logic [RS_IDX_W-1:0]   w_iss_idx;
    logic                  w_iss_found;
    logic                  w_dis_ok;
    rs_entry_t             w_new;

    // Issue candidates come only from registered state, so fresh wakeups wait a cycle.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < RS_SIZE; i++)
            w_cand[i] = r_busy[i] && r_ent[i].rj && r_ent[i].rk;
    end

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
        .i_req   (~r_busy),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_iss_sel (
        .i_req   (w_cand),
        .o_idx   (w_iss_idx),
        .o_found (w_iss_found)
    );

    // Full ignores a same-cycle issue; dispatch only ever targets a slot free before the edge.
    assign rs_full  = &r_busy;
    assign w_dis_ok = dis_valid && !rs_full && w_free_found;

    // Build the incoming entry, catching any operand broadcast in the dispatch cycle.
    always_comb begin
        w_new.op     = dis_op;
        w_new.optype = dis_opType;
        w_new.vj     = dis_rs1_val;
        w_new.vk     = dis_rs2_val;
        w_new.qj     = dis_rs1_tag;
        w_new.qk     = dis_rs2_tag;
        w_new.rj     = dis_rs1_rdy;
        w_new.rk     = dis_rs2_rdy;
        w_new.imm    = dis_imm;
        w_new.pc     = dis_PC;
        w_new.rob    = dis_rob_index;
        if (!dis_rs1_rdy) begin
            if (alu_ready && alu_rob_index == dis_rs1_tag) begin
                w_new.vj = alu_result;
                w_new.rj = 1'b1;
            end else if (lsb_ready && lsb_rob_index == dis_rs1_tag) begin
                w_new.vj = lsb_result;
                w_new.rj = 1'b1;
            end
        end
        if (!dis_rs2_rdy) begin
            if (alu_ready && alu_rob_index == dis_rs2_tag) begin
                w_new.vk = alu_result;
                w_new.rk = 1'b1;
            end else if (lsb_ready && lsb_rob_index == dis_rs2_tag) begin
                w_new.vk = lsb_result;
                w_new.rk = 1'b1;
            end
        end
    end

    // Slot state: wakeup snoop, issue (frees the slot) and dispatch into the lowest free slot.
    always_ff @(posedge clk_in) begin
        if (rst_in || clr_in) begin
            r_busy    <= '0;
            r_iss_vld <= 1'b0;
            r_iss     <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && !r_ent[i].rj) begin
                    if (alu_ready && alu_rob_index == r_ent[i].qj) begin
                        r_ent[i].vj <= alu_result;
                        r_ent[i].rj <= 1'b1;
                    end else if (lsb_ready && lsb_rob_index == r_ent[i].qj) begin
                        r_ent[i].vj <= lsb_result;
                        r_ent[i].rj <= 1'b1;
                    end
                end
                if (r_busy[i] && !r_ent[i].rk) begin
                    if (alu_ready && alu_rob_index == r_ent[i].qk) begin
                        r_ent[i].vk <= alu_result;
                        r_ent[i].rk <= 1'b1;
                    end else if (lsb_ready && lsb_rob_index == r_ent[i].qk) begin
                        r_ent[i].vk <= lsb_result;
                        r_ent[i].rk <= 1'b1;
                    end
                end
            end
            if (w_iss_found) begin
                r_iss             <= r_ent[w_iss_idx];
                r_iss_vld         <= 1'b1;
                r_busy[w_iss_idx] <= 1'b0;
            end else begin
                r_iss_vld <= 1'b0;
            end
            if (w_dis_ok) begin
                r_ent[w_free_idx]  <= w_new;
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    assign rs_to_alu_ready     = r_iss_vld;
    assign rs_to_alu_op        = r_iss.op;
    assign rs_to_alu_opType    = r_iss.optype;
    assign rs_to_alu_rs1       = r_iss.vj;
    assign rs_to_alu_rs2       = r_iss.vk;
    assign rs_to_alu_rob_index = r_iss.rob;
    assign rs_to_alu_PC        = r_iss.pc;
    assign rs_to_alu_imm       = r_iss.imm;

endmodule
